// File: rtl/ne16_tcdm_responder_if.sv
// ne16_tcdm_responder_if: per-port TCDM bus bundle (req/gnt handshake plus r_valid/r_data response)
//   master: drives req, add, wen (1 = read), be, data; receives gnt, r_data, r_valid
//   slave : the memory side, mirror of master
interface ne16_tcdm_responder_if #(
    parameter int unsigned MP = 4
);
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;
    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/ne16_tcdm_responder.sv
// ne16_tcdm_responder: banked multi-port TCDM slave with per-bank round-robin arbitration and 1-cycle responses
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (memory contents are not reset)
//   tcdm   : MP-port TCDM slave bundle; gnt is combinational from this cycle's requests
module ne16_tcdm_responder #(
    parameter int unsigned MP        = 4,
    parameter int unsigned NB        = 8,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    ne16_tcdm_responder_if.slave tcdm
);
    localparam int unsigned WW = $clog2(MEM_WORDS);
    localparam int unsigned BW = NB > 1 ? $clog2(NB) : 1;
    localparam int unsigned RD = MEM_WORDS / NB;
    localparam int unsigned RW = RD > 1 ? $clog2(RD) : 1;
    localparam int unsigned PW = MP > 1 ? $clog2(MP) : 1;

    logic [31:0]           mem [NB][RD];
    logic [31:0]           brd_q [NB];
    logic [MP-1:0][BW-1:0] bank;
    logic [MP-1:0][RW-1:0] row;
    logic [MP-1:0]         mask;
    logic [NB-1:0][PW-1:0] rr_q, rr_d, bwin;
    logic [NB-1:0]         bhit, bact;
    logic [PW-1:0]         cand;
    logic [MP-1:0]         valid_q, rd_q;
    logic [MP-1:0][BW-1:0] rbank_q;
    logic [MP-1:0][31:0]   hold_q;

    for (genvar p = 0; p < MP; p++) begin : g_port
        logic [WW-1:0] word;
        // Address wraps modulo the memory size; bits [1:0] are dropped by the shift.
        assign word    = WW'((tcdm.add[p] - BASE_ADDR) >> 2);
        assign bank[p] = BW'(32'(word) % NB);
        assign row[p]  = RW'(32'(word) / NB);
        // A write returns zero; otherwise the bank's latched read word, or the held value when idle.
        assign tcdm.r_data[p] = valid_q[p] ? (rd_q[p] ? brd_q[rbank_q[p]] : '0) : hold_q[p];
    end
    assign tcdm.r_valid = valid_q;

    if (STALL_EN) begin : g_lfsr
        logic [15:0] lfsr_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) lfsr_q <= LFSR_SEED;
            else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        for (genvar p = 0; p < MP; p++) begin : g_mask
            assign mask[p] = lfsr_q[p % 16];
        end
    end else begin : g_nostall
        assign mask = '1;
    end

    // Per bank: scan ports downward from rr_ptr+MP-1 so the last hit is the first port at or after rr_ptr.
    // A stalled winner blocks the bank for the cycle and leaves rr_ptr untouched.
    always_comb begin
        tcdm.gnt = '0;
        rr_d     = rr_q;
        bwin     = '0;
        bhit     = '0;
        bact     = '0;
        cand     = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = MP - 1; i >= 0; i--) begin
                cand = PW'((32'(rr_q[b]) + 32'(i)) % MP);
                if (tcdm.req[cand] && bank[cand] == BW'(b)) begin
                    bhit[b] = 1'b1;
                    bwin[b] = cand;
                end
            end
            if (bhit[b] && mask[bwin[b]]) begin
                bact[b]            = 1'b1;
                tcdm.gnt[bwin[b]]  = 1'b1;
                rr_d[b]            = PW'((32'(bwin[b]) + 1) % MP);
            end
        end
    end

    // One access per bank per cycle; reads see the contents before this cycle's writes.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (bact[b]) begin
                if (tcdm.wen[bwin[b]]) brd_q[b] <= mem[b][row[bwin[b]]];
                else for (int k = 0; k < 4; k++)
                    if (tcdm.be[bwin[b]][k]) mem[b][row[bwin[b]]][8*k +: 8] <= tcdm.data[bwin[b]][8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            valid_q <= '0;
            rd_q    <= '0;
            rbank_q <= '0;
            hold_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            valid_q <= tcdm.gnt;
            rd_q    <= tcdm.wen;
            rbank_q <= bank;
            hold_q  <= tcdm.r_data;
        end
    end
endmodule

// File: tb/tb_ne16_tcdm_responder.sv
// tb_ne16_tcdm_responder: scoreboard bench driving a non-stalling and a stalling responder with identical stimulus
module tb_ne16_tcdm_responder;
    localparam int MP = 4, NB = 8, MW = 4096;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [MP-1:0]       req = '0, wen = '0;
    logic [MP-1:0][31:0] add = '0, wd = '0;
    logic [MP-1:0][3:0]  be = '0;
    int tests = 0, fails = 0;

    ne16_tcdm_responder_if #(.MP(MP)) if0 ();
    ne16_tcdm_responder_if #(.MP(MP)) if1 ();
    assign if0.req = req;  assign if0.wen = wen;  assign if0.add = add;  assign if0.data = wd;  assign if0.be = be;
    assign if1.req = req;  assign if1.wen = wen;  assign if1.add = add;  assign if1.data = wd;  assign if1.be = be;

    ne16_tcdm_responder #(.MP(MP), .NB(NB), .MEM_WORDS(MW), .BASE_ADDR(BASE), .STALL_EN(1'b0), .LFSR_SEED(SEED))
        dut0 (.clk_i(clk), .rst_ni(rst_n), .tcdm(if0));
    ne16_tcdm_responder #(.MP(MP), .NB(NB), .MEM_WORDS(MW), .BASE_ADDR(BASE), .STALL_EN(1'b1), .LFSR_SEED(SEED))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .tcdm(if1));

    // Reference model: flat word memory with per-byte "known" flags, one per DUT.
    logic [31:0] mm [2][MW];
    logic [3:0]  kn [2][MW];
    int          ptr [2][NB];
    logic [15:0] lf = SEED;
    logic [63:0] exq [2][MP][$];
    logic [31:0] last [2][MP];

    function automatic logic [MP-1:0] gnt_of(input int d);
        return d != 0 ? if1.gnt : if0.gnt;
    endfunction
    function automatic logic [MP-1:0] rv_of(input int d);
        return d != 0 ? if1.r_valid : if0.r_valid;
    endfunction
    function automatic logic [31:0] rd_of(input int d, input int p);
        return d != 0 ? if1.r_data[p] : if0.r_data[p];
    endfunction
    function automatic int wrd(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % 32'(MW));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        logic [MP-1:0] eg;
        logic [31:0]   m;
        int win, q, w;
        eg = '0;
        for (int b = 0; b < NB; b++) begin
            win = -1;
            for (int i = 0; i < MP; i++) begin
                q = (ptr[d][b] + i) % MP;
                if (win < 0 && req[q] && wrd(add[q]) % NB == b) win = q;
            end
            if (win >= 0 && (d == 0 || lf[win % 16])) begin
                eg[win] = 1'b1;
                ptr[d][b] = (win + 1) % MP;
            end
        end
        chk($sformatf("gnt dut%0d", d), 32'(gnt_of(d)), 32'(eg));
        for (int p = 0; p < MP; p++) begin
            if (eg[p]) begin
                w = wrd(add[p]);
                if (wen[p]) begin
                    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{kn[d][w][k]}};
                    exq[d][p].push_back({m, mm[d][w]});
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (be[p][k]) begin
                            mm[d][w][8*k +: 8] = wd[p][8*k +: 8];
                            kn[d][w][k] = 1'b1;
                        end
                    exq[d][p].push_back({32'hFFFF_FFFF, 32'h0});
                end
            end
        end
        if (d == 1) lf = (lf << 1) | 16'(^(lf & 16'hB400));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            lf = SEED;
            for (int d = 0; d < 2; d++) begin
                for (int b = 0; b < NB; b++) ptr[d][b] = 0;
                for (int p = 0; p < MP; p++) exq[d][p].delete();
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Monitor: pops an expectation for every r_valid; checks hold and reset behaviour otherwise.
    always @(negedge clk) begin
        logic [63:0] e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < MP; p++) begin
                if (!rst_n) begin
                    chk($sformatf("reset r_valid dut%0d p%0d", d, p), 32'(rv_of(d)[p]), 32'h0);
                    chk($sformatf("reset r_data dut%0d p%0d", d, p), rd_of(d, p), 32'h0);
                    last[d][p] = '0;
                end else if (rv_of(d)[p]) begin
                    if (exq[d][p].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL resp dut%0d p%0d: got unexpected r_valid, want none", d, p);
                    end else begin
                        e = exq[d][p].pop_front();
                        if (e[63:32] != 0)
                            chk($sformatf("r_data dut%0d p%0d", d, p), rd_of(d, p) & e[63:32], e[31:0] & e[63:32]);
                    end
                    last[d][p] = rd_of(d, p);
                end else begin
                    chk($sformatf("hold dut%0d p%0d", d, p), rd_of(d, p), last[d][p]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic nb();
        @(negedge clk);
        #1;
    endtask
    task automatic put(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] dd, input logic [3:0] b);
        req[p] = r; wen[p] = w; add[p] = a; wd[p] = dd; be[p] = b;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MW; i++) begin
                kn[d][i] = '0;
                mm[d][i] = '0;
            end
        nb();
        chk("reset gnt", 32'(if0.gnt), 32'h0);
        tick();
        rst_n = 1'b1;
        // Single-port write then read
        put(0, 1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        nb(); chk("t1 write gnt", 32'(if0.gnt), 32'h1); tick();
        put(0, 1, 1, BASE + 32'h10, 32'h0, 4'h0);
        nb(); chk("t1 read gnt", 32'(if0.gnt), 32'h1);
        chk("t1 write r_valid", 32'(if0.r_valid), 32'h1);
        chk("t1 write r_data", if0.r_data[0], 32'h0); tick();
        req = '0;
        nb(); chk("t1 read r_valid", 32'(if0.r_valid), 32'h1);
        chk("t1 read r_data", if0.r_data[0], 32'hDEAD_BEEF); tick();
        // Wide conflict-free access, banks 0..3
        for (int p = 0; p < MP; p++) put(p, 1, 0, BASE + 32'(4 * p), 32'hC0DE_0000 + 32'(p * 17), 4'hF);
        nb(); chk("wide write gnt", 32'(if0.gnt), 32'hF); tick();
        for (int p = 0; p < MP; p++) put(p, 1, 1, BASE + 32'(4 * p), 32'h0, 4'h0);
        nb(); chk("wide read gnt", 32'(if0.gnt), 32'hF); tick();
        req = '0;
        nb(); chk("wide r_valid", 32'(if0.r_valid), 32'hF);
        for (int p = 0; p < MP; p++) chk($sformatf("wide r_data p%0d", p), if0.r_data[p], 32'hC0DE_0000 + 32'(p * 17));
        tick();
        // Bank-3 conflict between ports 0 and 1, each held until granted
        put(0, 1, 1, BASE + 32'h0C, 32'h0, 4'h0);
        put(1, 1, 1, BASE + 32'h2C, 32'h0, 4'h0);
        nb(); chk("conflict c0 gnt", 32'(if0.gnt), 32'h1); tick();
        req[0] = 1'b0;
        nb(); chk("conflict c1 gnt", 32'(if0.gnt), 32'h2); tick();
        req[0] = 1'b1;
        nb(); chk("conflict repeat gnt", 32'(if0.gnt), 32'h1); tick();
        req[0] = 1'b0;
        nb(); chk("conflict repeat c1 gnt", 32'(if0.gnt), 32'h2); tick();
        req = '0;
        // Byte enables
        put(2, 1, 0, BASE + 32'h40, 32'h1122_3344, 4'hF); nb(); tick();
        put(2, 1, 0, BASE + 32'h40, 32'hAABB_CCDD, 4'b0101); nb(); tick();
        put(2, 1, 1, BASE + 32'h40, 32'h0, 4'h0); nb(); tick();
        req = '0;
        nb(); chk("byte enable r_data", if0.r_data[2], 32'h11BB_33DD); tick();
        // Random traffic: continuous requests first, then sparse
        for (int i = 0; i < 1000; i++) begin
            for (int p = 0; p < MP; p++) begin
                logic [31:0] w;
                w = $urandom_range(0, 9) == 0 ? $urandom : $urandom_range(0, 127);
                put(p, i < 500 || $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    BASE + (w << 2) + 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            end
            tick();
        end
        req = '0;
        tick();
        // Reset right after a read grant; memory must survive
        put(0, 1, 0, BASE + 32'h80, 32'hCAFE_F00D, 4'hF); nb(); tick();
        put(0, 1, 1, BASE + 32'h80, 32'h0, 4'h0);
        nb(); chk("pre-reset read gnt", 32'(if0.gnt), 32'h1); tick();
        req = '0;
        rst_n = 1'b0;
        nb(); chk("reset drops r_valid", 32'(if0.r_valid), 32'h0); tick();
        tick();
        rst_n = 1'b1;
        nb(); chk("post-reset r_valid", 32'(if0.r_valid), 32'h0); tick();
        put(0, 1, 1, BASE + 32'h80, 32'h0, 4'h0); nb(); tick();
        req = '0;
        nb(); chk("retained r_valid", 32'(if0.r_valid), 32'h1);
        chk("retained r_data", if0.r_data[0], 32'hCAFE_F00D); tick();
        repeat (5) tick();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < MP; p++)
                chk($sformatf("drain dut%0d p%0d", d, p), 32'(exq[d][p].size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
